// File: rtl/pe_pkg.sv
// Shared widths, lane types and the saturating accumulate helper for the PE row drain.
package pe_pkg;

  localparam int unsigned LANES      = 16;
  localparam int unsigned PROD_W     = 16;
  localparam int unsigned ACC_W      = 24;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned FIFO_DEPTH = 2;
  // Working width for sat_add; any accumulator up to 31 bits fits without wrap.
  localparam int unsigned SUM_W      = 32;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef prod_t [LANES-1:0]        lane_prod_t;
  typedef acc_t  [LANES-1:0]        lane_acc_t;

  typedef struct packed {
    logic                    sat;
    logic signed [SUM_W-1:0] val;
  } sat_res_t;

  // Add two sign-extended operands one bit wider, then clamp to a w-bit signed range.
  function automatic sat_res_t sat_add(input logic signed [SUM_W-1:0] a,
                                       input logic signed [SUM_W-1:0] b,
                                       input int unsigned             w);
    logic signed [SUM_W:0] s;
    logic signed [SUM_W:0] hi;
    logic signed [SUM_W:0] lo;
    sat_res_t              r;
    s  = {a[SUM_W-1], a} + {b[SUM_W-1], b};
    hi = ((SUM_W+1)'(1) << (w - 1)) - (SUM_W+1)'(1);
    lo = ~hi;
    r.sat = 1'b0;
    r.val = s[SUM_W-1:0];
    if (s > hi) begin
      r.sat = 1'b1;
      r.val = hi[SUM_W-1:0];
    end else if (s < lo) begin
      r.sat = 1'b1;
      r.val = lo[SUM_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_row_psum_drain_if.sv
// Product-in and psum-out handshake bundle between PE row, drain and write-back.
interface pe_row_psum_drain_if
  import pe_pkg::*;
#(
  parameter int unsigned OUT_W = ACC_W
);
  logic                              in_valid;
  logic                              in_ready;
  logic [LANES-1:0][PROD_W-1:0]      product;
  logic                              out_valid;
  logic                              out_ready;
  logic [LANES-1:0][OUT_W-1:0]       out_psum;
  logic [LANES-1:0]                  out_sat;

  modport master (output in_valid, product, out_ready,
                  input  in_ready, out_valid, out_psum, out_sat);
  modport slave  (input  in_valid, product, out_ready,
                  output in_ready, out_valid, out_psum, out_sat);
endinterface

// File: rtl/psum_fifo.sv
// Small synchronous FIFO holding completed lane-vectors with their sat flags.
module psum_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push_i,
  input  logic [DATA_W-1:0]                  wr_data_i,
  input  logic                               pop_i,
  output logic [DATA_W-1:0]                  rd_data_o,
  output logic                               full_o,
  output logic                               empty_o,
  output logic [$clog2(DEPTH+1)-1:0]         count_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/pe_row_psum_drain.sv
// Per-lane windowed saturating accumulation of PE row products, drained through a FIFO.
module pe_row_psum_drain
  import pe_pkg::*;
#(
  parameter int unsigned OUT_W = ACC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LEN_W-1:0]     cfg_len,
  pe_row_psum_drain_if.slave   bus,
  output logic                 busy
);
  localparam int unsigned CNT_W   = LEN_W + 1;
  localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_W = LANES * OUT_W + LANES;

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]            len_q, len_d;
  logic [LANES-1:0][OUT_W-1:0] acc_q, acc_d;
  logic [LANES-1:0]            sat_q, sat_d;

  logic [CNT_W-1:0]            len_eff_c;
  logic [LANES-1:0][OUT_W-1:0] base_c;
  sat_res_t [LANES-1:0]        res_c;
  logic [LANES-1:0][OUT_W-1:0] sum_c;
  logic [LANES-1:0]            sat_c;
  logic                        in_ready_c;
  logic                        fire_c;
  logic                        start_c;
  logic                        last_c;
  logic                        push_c;
  logic                        pop_c;

  logic                        fifo_full;
  logic                        fifo_empty;
  logic [FCNT_W-1:0]           fifo_count;
  logic [ENTRY_W-1:0]          fifo_rd;

  // Acceptance depends only on FIFO occupancy, never on out_ready.
  assign in_ready_c    = (fifo_count < FCNT_W'(FIFO_DEPTH));
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = ~fifo_empty;
  assign pop_c         = ~fifo_empty & bus.out_ready;
  assign busy          = (cnt_q != '0);
  assign {bus.out_sat, bus.out_psum} = fifo_rd;

  // Lane sums, window bookkeeping and the final-beat push.
  always_comb begin
    cnt_d  = cnt_q;
    len_d  = len_q;
    acc_d  = acc_q;
    sat_d  = sat_q;
    push_c = 1'b0;

    fire_c    = bus.in_valid & in_ready_c;
    start_c   = (cnt_q == '0);
    len_eff_c = start_c ? ((cfg_len == '0) ? CNT_W'(2 ** LEN_W) : CNT_W'(cfg_len)) : len_q;
    last_c    = ((cnt_q + CNT_W'(1)) == len_eff_c);

    for (int i = 0; i < int'(LANES); i++) begin
      base_c[i] = start_c ? '0 : acc_q[i];
      res_c[i]  = sat_add(SUM_W'($signed(base_c[i])), SUM_W'($signed(bus.product[i])), OUT_W);
      sum_c[i]  = OUT_W'(res_c[i].val);
      sat_c[i]  = res_c[i].sat | (~start_c & sat_q[i]);
    end

    if (fire_c) begin
      len_d = len_eff_c;
      if (last_c) begin
        push_c = ~fifo_full;
        cnt_d  = '0;
        acc_d  = '0;
        sat_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = sum_c;
        sat_d = sat_c;
      end
    end
  end

  // Window state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      len_q <= '0;
      acc_q <= '0;
      sat_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  psum_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_c),
    .wr_data_i ({sat_c, sum_c}),
    .pop_i     (pop_c),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );
endmodule

// File: tb/tb_pe_row_psum_drain.sv
// Scoreboard bench for pe_row_psum_drain with a lane-level arithmetic reference model.
module tb_pe_row_psum_drain;
  import pe_pkg::*;

  // Narrow accumulator so clamping is reachable inside a 256-beat window.
  localparam int unsigned OUT_W = 20;
  localparam int MAXV = (1 <<< (OUT_W - 1)) - 1;
  localparam int MINV = -(1 <<< (OUT_W - 1));

  typedef logic [LANES-1:0][OUT_W-1:0] psum_vec_t;
  typedef struct packed {
    psum_vec_t        psum;
    logic [LANES-1:0] sat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [LEN_W-1:0] cfg_len;
  logic             busy;

  pe_row_psum_drain_if #(.OUT_W(OUT_W)) bus ();

  pe_row_psum_drain #(.OUT_W(OUT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_len (cfg_len),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  int   rdy_mode = 0;   // 0: always ready, 1: hold off, 2: random

  int acc_m [LANES];
  bit sat_m [LANES];
  int cnt_m = 0;
  int len_m = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    cnt_m = 0;
    exp_q.delete();
  endtask

  // Reference: each accepted beat adds into its lane, clamping at every step.
  task automatic model_beat(input int p [LANES]);
    exp_t e;
    if (cnt_m == 0) begin
      len_m = (cfg_len == 0) ? 256 : int'(cfg_len);
      for (int i = 0; i < int'(LANES); i++) begin
        acc_m[i] = 0;
        sat_m[i] = 1'b0;
      end
    end
    for (int i = 0; i < int'(LANES); i++) begin
      int s;
      s = acc_m[i] + p[i];
      if (s > MAXV) begin s = MAXV; sat_m[i] = 1'b1; end
      if (s < MINV) begin s = MINV; sat_m[i] = 1'b1; end
      acc_m[i] = s;
    end
    cnt_m++;
    if (cnt_m == len_m) begin
      for (int i = 0; i < int'(LANES); i++) begin
        e.psum[i] = OUT_W'(acc_m[i]);
        e.sat[i]  = sat_m[i];
      end
      exp_q.push_back(e);
      cnt_m = 0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is taken.
  task automatic send_beat(input int p [LANES]);
    int t;
    t = 0;
    for (int i = 0; i < int'(LANES); i++) bus.product[i] = PROD_W'(p[i]);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", t);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_beat(p);
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic fill(output int p [LANES], input int v);
    for (int i = 0; i < int'(LANES); i++) p[i] = v;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: compare head of queue whenever out_valid; pop when the handshake completes.
  initial begin
    logic r;
    exp_t got;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = 1'b0;
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (!rst && bus.out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output: got out_valid=1, expected no pending window");
        end else begin
          got.psum = bus.out_psum;
          got.sat  = bus.out_sat;
          if (got !== exp_q[0]) begin
            n_bad++;
            $display("FAIL out_window: got psum=%h sat=%h, expected psum=%h sat=%h",
                     got.psum, got.sat, exp_q[0].psum, exp_q[0].sat);
          end
          if (r) void'(exp_q.pop_front());
        end
      end
      bus.out_ready = r;
    end
  end

  initial begin
    int p [LANES];
    rst          = 1'b1;
    cfg_len      = LEN_W'(1);
    bus.in_valid = 1'b0;
    bus.product  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_psum_zero", (bus.out_psum == '0), 1);
    check("rst_sat_zero", bus.out_sat, 0);

    // Single-beat window, one-cycle latency, then pop
    cfg_len = LEN_W'(1);
    fill(p, 3);
    send_beat(p);
    check("t1_out_valid_rise", bus.out_valid, 1);
    check("t1_lane7", int'($signed(bus.out_psum[7])), 3);
    @(negedge clk);
    check("t1_out_valid_fall", bus.out_valid, 0);

    // Four-beat window with lane-dependent products
    cfg_len = LEN_W'(4);
    for (int i = 0; i < int'(LANES); i++) p[i] = i - 8;
    for (int b = 0; b < 4; b++) begin
      send_beat(p);
      check("t2_busy", busy, (b < 3) ? 1 : 0);
    end
    check("t2_lane0", int'($signed(bus.out_psum[0])), -32);
    check("t2_lane15", int'($signed(bus.out_psum[15])), 28);

    // Clamping in both directions
    cfg_len = LEN_W'(20);
    fill(p, 0);
    p[0] = 32767;
    p[1] = -32768;
    for (int b = 0; b < 20; b++) send_beat(p);
    check("t3_lane0", int'($signed(bus.out_psum[0])), MAXV);
    check("t3_lane1", int'($signed(bus.out_psum[1])), MINV);
    check("t3_sat_low", bus.out_sat[1:0], 3);
    check("t3_sat_high", bus.out_sat[15:2], 0);
    check("t3_lane9", int'($signed(bus.out_psum[9])), 0);
    wait_drain();

    // Backpressure: full FIFO stalls input, nothing lost
    rdy_mode = 1;
    @(negedge clk);
    cfg_len = LEN_W'(1);
    fill(p, 1); send_beat(p);
    fill(p, 2); send_beat(p);
    check("t4_in_ready_full", bus.in_ready, 0);
    for (int i = 0; i < int'(LANES); i++) bus.product[i] = PROD_W'(3);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t4_in_ready_held", bus.in_ready, 0);
      check("t4_out_valid_held", bus.out_valid, 1);
    end
    rdy_mode = 0;
    fill(p, 3); send_beat(p);
    wait_drain();

    // Reset mid-window discards the partial sums
    cfg_len = LEN_W'(4);
    fill(p, 5);
    send_beat(p);
    send_beat(p);
    check("t5_busy_before", busy, 1);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy_after", busy, 0);
    check("t5_out_valid_after", bus.out_valid, 0);
    fill(p, 1);
    for (int b = 0; b < 4; b++) send_beat(p);
    check("t5_lane3", int'($signed(bus.out_psum[3])), 4);
    wait_drain();

    // Back-to-back single-beat windows at full rate
    cfg_len = LEN_W'(1);
    for (int v = 0; v < 10; v++) begin
      check("t6_in_ready", bus.in_ready, 1);
      fill(p, v);
      send_beat(p);
      check("t6_out_valid", bus.out_valid, 1);
    end
    wait_drain();

    // Randomized windows, random gaps and random consumer stalls
    rdy_mode = 2;
    for (int b = 0; b < 400; b++) begin
      cfg_len = LEN_W'($urandom_range(1, 40));
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < int'(LANES); i++)
          p[i] = (i % 2 == 0) ? 32767 - int'($urandom_range(0, 1000))
                              : -32768 + int'($urandom_range(0, 1000));
      end else begin
        for (int i = 0; i < int'(LANES); i++) p[i] = int'($urandom_range(0, 65535)) - 32768;
      end
      send_beat(p);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    // Finish any open window with the latched length, then a full 256-beat window
    while (cnt_m != 0) begin
      fill(p, 1);
      send_beat(p);
    end
    cfg_len = '0;
    for (int b = 0; b < 256; b++) begin
      for (int i = 0; i < int'(LANES); i++) p[i] = int'($urandom_range(0, 8191)) - 2048;
      send_beat(p);
    end
    rdy_mode = 0;
    wait_drain();
    repeat (3) @(negedge clk);
    check("end_out_valid", bus.out_valid, 0);
    check("end_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
